dht11_reader: RTL

DHT11_READER -- requirements
Module: dht11_reader

---
 rtl/dht11_pkg.sv | 29 ++
 rtl/us_tick.sv | 29 ++
 rtl/dht11_reader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire sensor reader.
package dht11_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStartLow,
      StRelease,
      StRespLow,
      StRespHigh,
      StBitLow,
      StBitHigh,
      StCheck
   } state_e;

   localparam logic [1:0] ErrOk       = 2'd0;
   localparam logic [1:0] ErrTimeout  = 2'd1;
   localparam logic [1:0] ErrChecksum = 2'd2;

   // High phases longer than this many microseconds decode as a 1 bit.
   localparam logic [15:0] BitThreshUs = 16'd40;
   localparam logic [5:0]  LastBitIdx  = 6'd39;

   function automatic logic checksum_ok(input logic [39:0] frame);
      logic [7:0] sum;
      sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
      return sum == frame[7:0];
   endfunction

endpackage

// File: rtl/us_tick.sv
// One-cycle strobe every microsecond, derived from the system clock frequency.
module us_tick #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int unsigned Div    = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
   localparam int unsigned CntW   = (Div > 1) ? $clog2(Div) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = (cnt_q == CntMax);
      cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 reader: issues the host start pulse, times the sensor response and
// decodes the 40-bit frame, publishing humidity/temperature on a good checksum.
module dht11_reader
   import dht11_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned START_LOW_US = 20000,
   parameter int unsigned TIMEOUT_US   = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dht_in,
   output logic       dht_oe,
   output logic       busy,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec,
   output logic       valid,
   output logic [1:0] err
);

   localparam logic [15:0] StartLowCnt = 16'(START_LOW_US);
   localparam logic [15:0] TimeoutCnt  = 16'(TIMEOUT_US);

   state_e      state_q, state_d;
   logic        sync1_q, sync2_q, line_prev_q;
   logic [15:0] us_cnt_q, us_cnt_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [39:0] shift_q, shift_d;
   logic [31:0] data_q, data_d;
   logic [1:0]  err_q, err_d;
   logic        valid_q, valid_d;
   logic        tick, fall, rise, timeout;

   us_tick #(
      .CLK_HZ(CLK_HZ)
   ) u_us_tick (
      .clk_i (clk),
      .rst_i (rst),
      .tick_o(tick)
   );

   assign fall    = line_prev_q & ~sync2_q;
   assign rise    = ~line_prev_q & sync2_q;
   assign timeout = (us_cnt_q >= TimeoutCnt);

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      err_d     = err_q;
      valid_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) state_d = StStartLow;
         end
         // Line edges here are our own drive, so only the timer matters.
         StStartLow: begin
            if (us_cnt_q >= StartLowCnt) state_d = StRelease;
         end
         StRelease: begin
            if (fall) begin
               state_d   = StRespLow;
               bit_cnt_d = '0;
               shift_d   = '0;
            end else if (timeout) begin
               state_d = StIdle;
               err_d   = ErrTimeout;
            end
         end
         StRespLow: begin
            if (rise) begin
               state_d = StRespHigh;
            end else if (timeout) begin
               state_d = StIdle;
               err_d   = ErrTimeout;
            end
         end
         StRespHigh: begin
            if (fall) begin
               state_d = StBitLow;
            end else if (timeout) begin
               state_d = StIdle;
               err_d   = ErrTimeout;
            end
         end
         StBitLow: begin
            if (rise) begin
               state_d = StBitHigh;
            end else if (timeout) begin
               state_d = StIdle;
               err_d   = ErrTimeout;
            end
         end
         StBitHigh: begin
            if (fall) begin
               shift_d   = {shift_q[38:0], (us_cnt_q > BitThreshUs)};
               bit_cnt_d = bit_cnt_q + 6'd1;
               state_d   = (bit_cnt_q == LastBitIdx) ? StCheck : StBitLow;
            end else if (timeout) begin
               state_d = StIdle;
               err_d   = ErrTimeout;
            end
         end
         StCheck: begin
            state_d = StIdle;
            if (checksum_ok(shift_q)) begin
               data_d  = shift_q[39:8];
               valid_d = 1'b1;
               err_d   = ErrOk;
            end else begin
               err_d = ErrChecksum;
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q) begin
         us_cnt_d = '0;
      end else if (tick && (us_cnt_q != 16'hFFFF)) begin
         us_cnt_d = us_cnt_q + 16'd1;
      end else begin
         us_cnt_d = us_cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         line_prev_q <= 1'b1;
         us_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         err_q       <= ErrOk;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= dht_in;
         sync2_q     <= sync1_q;
         line_prev_q <= sync2_q;
         us_cnt_q    <= us_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         err_q       <= err_d;
         valid_q     <= valid_d;
      end
   end

   assign dht_oe   = (state_q == StStartLow);
   assign busy     = (state_q != StIdle);
   assign valid    = valid_q;
   assign err      = err_q;
   assign hum_int  = data_q[31:24];
   assign hum_dec  = data_q[23:16];
   assign temp_int = data_q[15:8];
   assign temp_dec = data_q[7:0];

endmodule
